por_reset_sequencer: RTL

//  Consumes the active-low POR output of the power-on-reset block (porb_l, 1.8V domain) and
//  the external pad reset. Produces staged, clk-synchronous resets: housekeeping first, then

---
 rtl/por_reset_sequencer_if.sv | 31 +++
 rtl/por_reset_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/por_reset_sequencer_if.sv
// Reset-sequencer status bundle: staged active-low resets,
// state/cause visibility and the software reset request.
interface por_reset_sequencer_if;
    logic       sw_reset_req;
    logic       rstn_hk;
    logic       rstn_core;
    logic       rstn_user;
    logic [2:0] seq_state;
    logic [1:0] reset_cause;
    logic       lock_timeout;

    modport master (
        input  sw_reset_req,
        output rstn_hk,
        output rstn_core,
        output rstn_user,
        output seq_state,
        output reset_cause,
        output lock_timeout
    );

    modport slave (
        output sw_reset_req,
        input  rstn_hk,
        input  rstn_core,
        input  rstn_user,
        input  seq_state,
        input  reset_cause,
        input  lock_timeout
    );
endinterface

// File: rtl/por_reset_sequencer.sv
// Staged reset release: housekeeping, then core (PLL lock
// or timeout), then user, with pad/software restart.
module por_reset_sequencer #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int HOLD_CYC     = 16,
    parameter int STAGE_GAP    = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic ext_resetb,
    input  logic pll_lock,
    por_reset_sequencer_if.master rs
);

    localparam int MAXP =
        (HOLD_CYC > STAGE_GAP)
            ? ((HOLD_CYC > LOCK_TIMEOUT) ? HOLD_CYC : LOCK_TIMEOUT)
            : ((STAGE_GAP > LOCK_TIMEOUT) ? STAGE_GAP : LOCK_TIMEOUT);
    localparam int CW = $clog2(MAXP + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_HK        = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_CORE      = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] rst_sync;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   run_en;
    logic                   ext_s;
    logic                   lock_s;

    logic [DW-1:0] deb_cnt;
    logic          ext_req;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hk_q, hk_d;
    logic          core_q, core_d;
    logic          user_q, user_d;
    logic [1:0]    cause_q, cause_d;
    logic          lto_q, lto_d;

    // ext sync idles high so a released pad never looks asserted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync  <= '0;
            ext_sync  <= '1;
            lock_sync <= '0;
        end else begin
            rst_sync  <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
            ext_sync  <= {ext_sync[SYNC_STAGES-2:0], ext_resetb};
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign run_en = rst_sync[SYNC_STAGES-1];
    assign ext_s  = ext_sync[SYNC_STAGES-1];
    assign lock_s = lock_sync[SYNC_STAGES-1];

    assign ext_req = (deb_cnt == DW'(DEBOUNCE_CYC));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            deb_cnt <= '0;
        end else if (ext_s) begin
            deb_cnt <= '0;
        end else if (!ext_req) begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            hk_q    <= 1'b0;
            core_q  <= 1'b0;
            user_q  <= 1'b0;
            cause_q <= 2'b00;
            lto_q   <= 1'b0;
        end else if (run_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hk_q    <= hk_d;
            core_q  <= core_d;
            user_q  <= user_d;
            cause_q <= cause_d;
            lto_q   <= lto_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        hk_d    = hk_q;
        core_d  = core_q;
        user_d  = user_q;
        cause_d = cause_q;
        lto_d   = lto_q;

        unique case (state_q)
            S_HOLD: begin
                if (!ext_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(HOLD_CYC - 1)) begin
                    state_d = S_HK;
                    cnt_d   = '0;
                    hk_d    = 1'b1;
                end
            end
            S_HK: begin
                if (cnt_q == CW'(STAGE_GAP - 1)) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_CORE;
                    cnt_d   = '0;
                    core_d  = 1'b1;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    state_d = S_CORE;
                    cnt_d   = '0;
                    core_d  = 1'b1;
                    lto_d   = 1'b1;
                end
            end
            S_CORE: begin
                if (cnt_q == CW'(STAGE_GAP - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    user_d  = 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
                hk_d    = 1'b0;
                core_d  = 1'b0;
                user_d  = 1'b0;
            end
        endcase

        // pad reset outranks the software request
        if (state_q != S_HOLD && (ext_req || rs.sw_reset_req)) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            hk_d    = 1'b0;
            core_d  = 1'b0;
            user_d  = 1'b0;
            cause_d = ext_req ? 2'b01 : 2'b10;
        end
    end

    assign rs.rstn_hk      = hk_q;
    assign rs.rstn_core    = core_q;
    assign rs.rstn_user    = user_q;
    assign rs.seq_state    = state_q;
    assign rs.reset_cause  = cause_q;
    assign rs.lock_timeout = lto_q;

endmodule
